// File: rtl/c17_trojan_scanner.sv
// Self-test initiator: sweeps all 32 c17 input patterns through an external DUT and
// compares its N22/N23 responses against an internal golden c17 model.
module c17_trojan_scanner #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   output logic [4:0] tp_vec,
   input  logic       dut_n22,
   input  logic       dut_n23,
   output logic       busy,
   output logic       done,
   output logic       result_valid,
   output logic [5:0] mismatch_count,
   output logic [4:0] first_fail_pattern,
   output logic       first_fail_valid,
   output logic [1:0] fail_mask,
   output logic       trojan_detected
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam int CW = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES);

   state_e        state_q, state_d;
   logic [4:0]    tp_q, tp_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    mc_q, mc_d;
   logic [4:0]    ffp_q, ffp_d;
   logic          ffv_q, ffv_d;
   logic [1:0]    fm_q, fm_d;
   logic          rv_q, rv_d;
   logic          td_q, td_d;

   logic n10, n11, n16, n19, gold_n22, gold_n23;
   logic [1:0] miss;
   logic sample, last_pat;

   assign n10      = ~(tp_q[4] & tp_q[2]);
   assign n11      = ~(tp_q[2] & tp_q[1]);
   assign n16      = ~(tp_q[3] & n11);
   assign n19      = ~(n11 & tp_q[0]);
   assign gold_n22 = ~(n10 & n16);
   assign gold_n23 = ~(n16 & n19);

   assign miss     = {dut_n22 ^ gold_n22, dut_n23 ^ gold_n23};
   assign last_pat = (tp_q == 5'd31);
   // abort wins over a compare that falls on the same edge
   assign sample   = (state_q == RUN) && (cnt_q == SETTLE_LAST) && !abort;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      // NOTE: default first so every path assigns state_d and no latch is inferred.
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN: begin
            if (abort)                    state_d = IDLE;
            else if (sample && last_pat)  state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
   end

   always_comb begin
      tp_d  = tp_q;
      cnt_d = cnt_q;
      mc_d  = mc_q;
      ffp_d = ffp_q;
      ffv_d = ffv_q;
      fm_d  = fm_q;
      rv_d  = rv_q;
      td_d  = td_q;
      case (state_q)
         IDLE: if (start) begin
            tp_d  = 5'd0;
            cnt_d = '0;
            mc_d  = 6'd0;
            ffp_d = 5'd0;
            ffv_d = 1'b0;
            fm_d  = 2'b00;
            rv_d  = 1'b0;
            td_d  = 1'b0;
         end
         RUN: begin
            if (abort) begin
               tp_d = 5'd0;
            end else if (sample) begin
               if (|miss) begin
                  mc_d = mc_q + 6'd1;
                  fm_d = fm_q | miss;
                  if (!ffv_q) begin
                     ffp_d = tp_q;
                     ffv_d = 1'b1;
                  end
               end
               if (!last_pat) begin
                  tp_d  = tp_q + 5'd1;
                  cnt_d = '0;
               end else begin
                  rv_d = 1'b1;
                  td_d = (mc_d != 6'd0);
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE:    tp_d = 5'd0;
         default: tp_d = 5'd0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: non-blocking so every register samples the pre-edge values of the others.
      if (rst) begin
         tp_q  <= 5'd0;
         cnt_q <= '0;
         mc_q  <= 6'd0;
         ffp_q <= 5'd0;
         ffv_q <= 1'b0;
         fm_q  <= 2'b00;
         rv_q  <= 1'b0;
         td_q  <= 1'b0;
      end else begin
         tp_q  <= tp_d;
         cnt_q <= cnt_d;
         mc_q  <= mc_d;
         ffp_q <= ffp_d;
         ffv_q <= ffv_d;
         fm_q  <= fm_d;
         rv_q  <= rv_d;
         td_q  <= td_d;
      end
   end

   assign tp_vec             = tp_q;
   assign mismatch_count     = mc_q;
   assign first_fail_pattern = ffp_q;
   assign first_fail_valid   = ffv_q;
   assign fail_mask          = fm_q;
   assign result_valid       = rv_q;
   assign trojan_detected    = td_q;

endmodule
